// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: shadows E/M/W destinations and Tnew,
// drives forwarding mux selects and D/E stall/flush. Define HAZ_STATS_EN to add the stall_cnt output.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TW-1:0]     d_tnew,
  input  logic              md_busy,
  input  logic              d_is_md,
  output logic              stall,
  output logic              e_flush,
  output logic [2:0]        fwd_d_rs,
  output logic [2:0]        fwd_d_rt,
  output logic [2:0]        fwd_e_rs,
  output logic [2:0]        fwd_e_rt,
  output logic [2:0]        fwd_m_rt
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [2:0] SEL_OWN = 3'b001;
  localparam logic [2:0] SEL_M   = 3'b010;
  localparam logic [2:0] SEL_W   = 3'b011;
  localparam logic [2:0] SEL_E   = 3'b100;

  logic [REG_AW-1:0] e_wa_r, e_rs_r, e_rt_r;
  logic [TW-1:0]     e_tnew_r;
  logic [REG_AW-1:0] m_wa_r, m_rs_r, m_rt_r;
  logic [TW-1:0]     m_tnew_r;
  logic [REG_AW-1:0] w_wa_r;
  logic [TW-1:0]     w_tnew_r;

  logic              stall_s;
  logic              hz_rs_s;
  logic              hz_rt_s;

  // $zero never matches, so it is never forwarded and never stalls.
  function automatic logic reg_hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] wa);
    return (r != {REG_AW{1'b0}}) && (wa == r);
  endfunction

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    logic [TW-1:0] res;
    if (t == {TW{1'b0}}) begin
      res = {TW{1'b0}};
    end else begin
      res = t - {{(TW-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // A younger match whose result is not ready hides older matches; the stall covers it.
  function automatic logic [2:0] d_select(
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] ewa, input logic [TW-1:0] etn,
    input logic [REG_AW-1:0] mwa, input logic [TW-1:0] mtn,
    input logic [REG_AW-1:0] wwa
  );
    logic [2:0] sel;
    if (reg_hit(r, ewa)) begin
      sel = (etn == {TW{1'b0}}) ? SEL_E : SEL_OWN;
    end else if (reg_hit(r, mwa)) begin
      sel = (mtn == {TW{1'b0}}) ? SEL_M : SEL_OWN;
    end else if (reg_hit(r, wwa)) begin
      sel = SEL_W;
    end else begin
      sel = SEL_OWN;
    end
    return sel;
  endfunction

  function automatic logic [2:0] e_select(
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] mwa, input logic [TW-1:0] mtn,
    input logic [REG_AW-1:0] wwa
  );
    logic [2:0] sel;
    if (reg_hit(r, mwa)) begin
      sel = (mtn == {TW{1'b0}}) ? SEL_M : SEL_OWN;
    end else if (reg_hit(r, wwa)) begin
      sel = SEL_W;
    end else begin
      sel = SEL_OWN;
    end
    return sel;
  endfunction

  function automatic logic src_hazard(
    input logic [REG_AW-1:0] r, input logic [TW-1:0] tuse,
    input logic [REG_AW-1:0] ewa, input logic [TW-1:0] etn,
    input logic [REG_AW-1:0] mwa, input logic [TW-1:0] mtn,
    input logic [REG_AW-1:0] wwa, input logic [TW-1:0] wtn
  );
    logic hz;
    if (reg_hit(r, ewa)) begin
      hz = (etn > tuse);
    end else if (reg_hit(r, mwa)) begin
      hz = (mtn > tuse);
    end else if (reg_hit(r, wwa)) begin
      hz = (wtn > tuse);
    end else begin
      hz = 1'b0;
    end
    return hz;
  endfunction

  // Hazard detection and forwarding selects, all zero-latency from shadow state and D inputs.
  always_comb begin
    hz_rs_s  = src_hazard(d_rs, d_tuse_rs, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r, w_wa_r, w_tnew_r);
    hz_rt_s  = src_hazard(d_rt, d_tuse_rt, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r, w_wa_r, w_tnew_r);
    stall_s  = d_valid & (hz_rs_s | hz_rt_s | (d_is_md & md_busy));
    stall    = stall_s;
    e_flush  = stall_s;
    fwd_d_rs = d_select(d_rs, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r, w_wa_r);
    fwd_d_rt = d_select(d_rt, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r, w_wa_r);
    fwd_e_rs = e_select(e_rs_r, m_wa_r, m_tnew_r, w_wa_r);
    fwd_e_rt = e_select(e_rt_r, m_wa_r, m_tnew_r, w_wa_r);
    if (reg_hit(m_rt_r, w_wa_r)) begin
      fwd_m_rt = SEL_W;
    end else begin
      fwd_m_rt = SEL_OWN;
    end
  end

  // Shadow pipeline: E takes D or a bubble; M and W always advance with saturating Tnew.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa_r   <= {REG_AW{1'b0}};
      e_rs_r   <= {REG_AW{1'b0}};
      e_rt_r   <= {REG_AW{1'b0}};
      e_tnew_r <= {TW{1'b0}};
      m_wa_r   <= {REG_AW{1'b0}};
      m_rs_r   <= {REG_AW{1'b0}};
      m_rt_r   <= {REG_AW{1'b0}};
      m_tnew_r <= {TW{1'b0}};
      w_wa_r   <= {REG_AW{1'b0}};
      w_tnew_r <= {TW{1'b0}};
    end else begin
      if (stall_s || !d_valid) begin
        e_wa_r   <= {REG_AW{1'b0}};
        e_rs_r   <= {REG_AW{1'b0}};
        e_rt_r   <= {REG_AW{1'b0}};
        e_tnew_r <= {TW{1'b0}};
      end else begin
        e_wa_r   <= d_wa;
        e_rs_r   <= d_rs;
        e_rt_r   <= d_rt;
        e_tnew_r <= d_tnew;
      end
      m_wa_r   <= e_wa_r;
      m_rs_r   <= e_rs_r;
      m_rt_r   <= e_rt_r;
      m_tnew_r <= dec_sat(e_tnew_r);
      w_wa_r   <= m_wa_r;
      w_tnew_r <= dec_sat(m_tnew_r);
    end
  end

`ifdef HAZ_STATS_EN
  // Free-running stall-cycle counter; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall_s) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl; checks stall/flush and every forwarding select.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       md_busy, d_is_md;
  logic       stall, e_flush;
  logic [2:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_forward_ctrl #(.REG_AW(5), .TW(2)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew), .md_busy(md_busy), .d_is_md(d_is_md),
    .stall(stall), .e_flush(e_flush),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] wa, input logic [1:0] tn);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_tnew = tn;
    #1;
  endtask

  task automatic idle(input int n);
    set_d(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; md_busy = 1'b0; d_is_md = 1'b0;
    set_d(1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 5'd5, 2'd0);
    tick(); tick();
    chk_val("rst_stall", {31'd0, stall}, 32'd0);
    chk_val("rst_flush", {31'd0, e_flush}, 32'd0);
    chk_val("rst_d_rs", {29'd0, fwd_d_rs}, 32'd1);
    chk_val("rst_d_rt", {29'd0, fwd_d_rt}, 32'd1);
    chk_val("rst_e_rs", {29'd0, fwd_e_rs}, 32'd1);
    chk_val("rst_e_rt", {29'd0, fwd_e_rt}, 32'd1);
    chk_val("rst_m_rt", {29'd0, fwd_m_rt}, 32'd1);
    reset = 1'b0;
    #1;
    chk_val("post_rst_d_rs", {29'd0, fwd_d_rs}, 32'd1);
    chk_val("post_rst_stall", {31'd0, stall}, 32'd0);
    idle(3);

    // ALU RAW consumed in E: no stall, M forward one cycle later
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 2'd1);
    chk_val("alu_prod_stall", {31'd0, stall}, 32'd0);
    tick();
    set_d(1'b1, 5'd8, 5'd2, 2'd1, 2'd1, 5'd10, 2'd1);
    chk_val("alu_use_stall", {31'd0, stall}, 32'd0);
    chk_val("alu_use_d_rs", {29'd0, fwd_d_rs}, 32'd1);
    tick();
    set_d(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("alu_e_rs", {29'd0, fwd_e_rs}, 32'd2);
    chk_val("alu_e_rt", {29'd0, fwd_e_rt}, 32'd1);
    idle(3);

    // branch consuming ALU result in D: one stall, then M forward
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 2'd1);
    tick();
    set_d(1'b1, 5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("beq_stall", {31'd0, stall}, 32'd1);
    chk_val("beq_flush", {31'd0, e_flush}, 32'd1);
    tick();
    chk_val("beq_stall_end", {31'd0, stall}, 32'd0);
    chk_val("beq_d_rs", {29'd0, fwd_d_rs}, 32'd2);
    idle(3);

    // load-use: one stall, then W forward into E; W forward into D too
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd2);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 2'd1, 2'd1, 5'd11, 2'd1);
    chk_val("lw_stall", {31'd0, stall}, 32'd1);
    chk_val("lw_flush", {31'd0, e_flush}, 32'd1);
    tick();
    chk_val("lw_stall_end", {31'd0, stall}, 32'd0);
    chk_val("lw_d_rs_blocked", {29'd0, fwd_d_rs}, 32'd1);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("lw_e_rs", {29'd0, fwd_e_rs}, 32'd3);
    chk_val("lw_d_rs_w", {29'd0, fwd_d_rs}, 32'd3);
    chk_val("lw_w_stall", {31'd0, stall}, 32'd0);
    idle(3);

    // jal link value forwarded from E to jr in D
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd31, 2'd0);
    tick();
    set_d(1'b1, 5'd31, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("jal_d_rs", {29'd0, fwd_d_rs}, 32'd4);
    chk_val("jal_stall", {31'd0, stall}, 32'd0);
    idle(3);

    // $zero never matches; E beats M; then E and M stage selects
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd2);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd0);
    chk_val("zero_stall", {31'd0, stall}, 32'd0);
    chk_val("zero_d_rs", {29'd0, fwd_d_rs}, 32'd1);
    chk_val("zero_d_rt", {29'd0, fwd_d_rt}, 32'd1);
    tick();
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd0);
    tick();
    set_d(1'b1, 5'd3, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("prio_d_rs", {29'd0, fwd_d_rs}, 32'd4);
    chk_val("prio_d_rt", {29'd0, fwd_d_rt}, 32'd4);
    chk_val("prio_stall", {31'd0, stall}, 32'd0);
    tick();
    set_d(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_val("prio_e_rs", {29'd0, fwd_e_rs}, 32'd2);
    chk_val("prio_e_rt", {29'd0, fwd_e_rt}, 32'd2);
    tick();
    chk_val("m_rt_w", {29'd0, fwd_m_rt}, 32'd3);
    chk_val("bubble_e_rs", {29'd0, fwd_e_rs}, 32'd1);
    idle(3);

    // mult/div busy: stall for every busy cycle
    md_busy = 1'b1; d_is_md = 1'b1;
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd4, 2'd1);
    for (int i = 0; i < 4; i++) begin
      chk_val("md_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    md_busy = 1'b0;
    #1;
    chk_val("md_stall_end", {31'd0, stall}, 32'd0);
`ifdef HAZ_STATS_EN
    chk_val("stall_cnt", stall_cnt, 32'd6);
`endif
    d_is_md = 1'b0;
    idle(3);

    // reset during a load-use stall clears state at that edge
    set_d(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd2);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 2'd1, 2'd1, 5'd11, 2'd1);
    chk_val("rst_mid_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_val("rst_mid_stall_end", {31'd0, stall}, 32'd0);
    chk_val("rst_mid_d_rs", {29'd0, fwd_d_rs}, 32'd1);
`ifdef HAZ_STATS_EN
    chk_val("stall_cnt_clr", stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
